uart_tx_fifo: RTL

Buffered UART transmitter. Accepts bytes from the command/telemetry logic through a small FIFO and serialises each one as 8N1, with optional parity, on the robot's serial line at `CLKS_PER_BIT` clocks per bit. It is the transmit-side companion of the existing UART receiver on the same link and uses the same bit timing and framing.

---
 rtl/uart_tx_fifo_if.sv | 38 +++
 rtl/uart_tx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-write handshake and status bundle between the command/telemetry logic
// and the buffered UART transmitter.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          i_TX_DV;
    logic [7:0]    i_TX_Byte;
    logic          o_TX_Ready;
    logic          o_TX_Serial;
    logic          o_TX_Active;
    logic          o_TX_Done;
    logic [CW-1:0] o_FIFO_Count;
    logic          o_Overflow;

    modport master (
        output i_TX_DV,
        output i_TX_Byte,
        input  o_TX_Ready,
        input  o_TX_Serial,
        input  o_TX_Active,
        input  o_TX_Done,
        input  o_FIFO_Count,
        input  o_Overflow
    );

    modport slave (
        input  i_TX_DV,
        input  i_TX_Byte,
        output o_TX_Ready,
        output o_TX_Serial,
        output o_TX_Active,
        output o_TX_Done,
        output o_FIFO_Count,
        output o_Overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with a small byte FIFO in front of it.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 195,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          i_Clock,
    input  logic          i_Rst_L,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [15:0]   LAST_CLK = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem [FIFO_DEPTH];

    logic wr_en;
    logic pop;
    logic last_clk;

    // Ready is the registered not-full flag, so a full FIFO rejects a write
    // even when the FSM pops in the same cycle.
    assign wr_en    = bus.i_TX_DV && ready_q;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign last_clk = (clk_cnt_q == LAST_CLK);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (bus.i_TX_DV && !ready_q) begin
            ovf_d = 1'b1;
        end
        ready_d = (count_d != FULL);
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (last_clk) begin
                    clk_cnt_d = '0;
                    state_d   = S_CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            S_CLEANUP: begin
                clk_cnt_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Line outputs are decoded from the next state so they change on the
    // same edge as the state itself.
    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_d)
            S_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
            end
            S_DATA: begin
                serial_d = shift_d[bit_idx_d];
                active_d = 1'b1;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                serial_d = ^shift_d;
                active_d = 1'b1;
            end
`endif
            S_STOP: begin
                active_d = 1'b1;
            end
            S_CLEANUP: begin
                done_d = 1'b1;
            end
            default: begin
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.i_TX_Byte;
        end
    end

    assign bus.o_TX_Ready   = ready_q;
    assign bus.o_TX_Serial  = serial_q;
    assign bus.o_TX_Active  = active_q;
    assign bus.o_TX_Done    = done_q;
    assign bus.o_FIFO_Count = count_q;
    assign bus.o_Overflow   = ovf_q;
endmodule
